m_param_ff_bank: RTL and testbench

M_PARAM_FF_BANK -- requirements
Module: m_param_ff_bank

---
 rtl/m_param_ff_bank_if.sv | 16 +
 rtl/m_param_ff_bank.sv | 60 ++++++
 tb/tb_m_param_ff_bank.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/m_param_ff_bank_if.sv
// m_param_ff_bank_if: button, mode, data and direct clear/preset into the flip-flop bank, plus its state, count and error outputs
//   master drives btn_1, mode_sel, a_in, b_in, rd_n, sd_n and reads q, q_n, cp_cnt, err; slave is the bank side
interface m_param_ff_bank_if #(parameter int WIDTH = 4);
  logic btn_1;
  logic [1:0] mode_sel;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic rd_n;
  logic sd_n;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic [7:0] cp_cnt;
  logic err;
  modport master(output btn_1, mode_sel, a_in, b_in, rd_n, sd_n, input q, q_n, cp_cnt, err);
  modport slave(input btn_1, mode_sel, a_in, b_in, rd_n, sd_n, output q, q_n, cp_cnt, err);
endinterface

// File: rtl/m_param_ff_bank.sv
// m_param_ff_bank: bank of WIDTH D/T/JK/SR flip-flops clocked by a debounced push-button
//   clk, rst (async, active-high); bus: btn_1, mode_sel, a_in, b_in, rd_n, sd_n in; q, q_n, cp_cnt, err out
module m_param_ff_bank #(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic clk,
  input logic rst,
  m_param_ff_bank_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0] btn_q, rd_q, sd_q;
  logic db_q, db_d, cp_q, cp_d, err_q, err_d, diff, done;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d, upd, a, b;
  logic [7:0] cnt_cp_q;
  always_comb begin
    a = bus.a_in;
    b = bus.b_in;
    diff = btn_q[1] != db_q;
    done = diff && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    cnt_d = diff && !done ? cnt_q + CW'(1) : '0;
    db_d = done ? btn_q[1] : db_q;
    cp_d = done && btn_q[1];
    // JK: set where J and q=0, keep where K=0 and q=1; SR: S&~R sets, ~S&R clears, else holds
    upd = bus.mode_sel == 2'd0 ? a :
          bus.mode_sel == 2'd1 ? q_q ^ a :
          bus.mode_sel == 2'd2 ? (a & ~q_q) | (~b & q_q) :
          (a & ~b) | (q_q & (a | ~b));
    q_d = !rd_q[1] ? '0 : !sd_q[1] ? '1 : cp_q ? upd : q_q;
    err_d = bus.mode_sel != 2'b11 ? 1'b0 :
            (cp_q && rd_q[1] && sd_q[1] && |(a & b)) ? 1'b1 : err_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      btn_q <= '0;
      rd_q <= '0;
      sd_q <= '0;
      cnt_q <= '0;
      db_q <= 1'b0;
      cp_q <= 1'b0;
      q_q <= '0;
      err_q <= 1'b0;
      cnt_cp_q <= '0;
    end else begin
      btn_q <= {btn_q[0], bus.btn_1};
      rd_q <= {rd_q[0], bus.rd_n};
      sd_q <= {sd_q[0], bus.sd_n};
      cnt_q <= cnt_d;
      db_q <= db_d;
      cp_q <= cp_d;
      q_q <= q_d;
      err_q <= err_d;
      cnt_cp_q <= cnt_cp_q + {7'd0, cp_q};
    end
  assign bus.q = q_q;
  assign bus.q_n = ~q_q;
  assign bus.cp_cnt = cnt_cp_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_m_param_ff_bank.sv
// tb_m_param_ff_bank: directed presses against a per-cycle behavioural model plus literal spot checks
module tb_m_param_ff_bank;
  localparam int DC = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  bit chk_en = 0;
  m_param_ff_bank_if #(.WIDTH(4)) bus();
  m_param_ff_bank #(.WIDTH(4), .DEBOUNCE_CYCLES(DC)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [1:0] m_bs, m_rs, m_ss;
  bit m_win[$];
  logic m_db, m_cp, m_err, ncp, nerr;
  logic [3:0] m_q, nq;
  logic [7:0] m_cnt;
  function automatic logic bit_next(logic [1:0] m, logic qb, logic a, logic b);
    case (m)
      2'd0: return a;
      2'd1: return qb ^ a;
      2'd2: case ({a, b}) 2'b00: return qb; 2'b01: return 1'b0; 2'b10: return 1'b1; default: return ~qb; endcase
      default: case ({a, b}) 2'b01: return 1'b0; 2'b10: return 1'b1; default: return qb; endcase
    endcase
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_bs = '0; m_rs = '0; m_ss = '0; m_win.delete();
      m_db = 0; m_cp = 0; m_err = 0; m_q = '0; m_cnt = '0;
    end else begin
      nq = m_q;
      nerr = m_err;
      if (!m_rs[1]) nq = '0;
      else if (!m_ss[1]) nq = '1;
      else if (m_cp) begin
        for (int i = 0; i < 4; i++) nq[i] = bit_next(bus.mode_sel, m_q[i], bus.a_in[i], bus.b_in[i]);
        if (bus.mode_sel == 2'b11 && |(bus.a_in & bus.b_in)) nerr = 1;
      end
      if (bus.mode_sel != 2'b11) nerr = 0;
      if (m_cp) m_cnt = m_cnt + 8'd1;
      ncp = 0;
      if (m_bs[1] == m_db) m_win.delete();
      else begin
        m_win.push_back(m_bs[1]);
        if (m_win.size() == DC) begin
          ncp = m_bs[1];
          m_db = m_bs[1];
          m_win.delete();
        end
      end
      m_cp = ncp; m_q = nq; m_err = nerr;
      m_bs = {m_bs[0], bus.btn_1};
      m_rs = {m_rs[0], bus.rd_n};
      m_ss = {m_ss[0], bus.sd_n};
    end
  task automatic check(string n, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (!rst && chk_en) begin
      check("model_q", {4'd0, bus.q}, {4'd0, m_q});
      check("model_q_n", {4'd0, bus.q_n}, {4'd0, ~m_q});
      check("model_cp_cnt", bus.cp_cnt, m_cnt);
      check("model_err", {7'd0, bus.err}, {7'd0, m_err});
    end
  task automatic press(logic [1:0] m, logic [3:0] a, logic [3:0] b);
    @(negedge clk);
    bus.mode_sel = m; bus.a_in = a; bus.b_in = b; bus.btn_1 = 1;
    repeat (8) @(negedge clk);
    bus.btn_1 = 0;
    repeat (10) @(negedge clk);
  endtask
  initial begin
    bus.btn_1 = 0; bus.mode_sel = 0; bus.a_in = 0; bus.b_in = 0; bus.rd_n = 1; bus.sd_n = 1;
    #1 rst = 1;
    repeat (2) @(negedge clk);
    check("rst_q", {4'd0, bus.q}, 8'h00);
    check("rst_q_n", {4'd0, bus.q_n}, 8'h0f);
    check("rst_cnt", bus.cp_cnt, 8'h00);
    check("rst_err", {7'd0, bus.err}, 8'h00);
    rst = 0; chk_en = 1;
    repeat (3) @(negedge clk);
    press(2'd0, 4'b1010, 4'b0000);
    check("d_q", {4'd0, bus.q}, 8'h0a);
    check("d_q_n", {4'd0, bus.q_n}, 8'h05);
    check("d_cnt", bus.cp_cnt, 8'd1);
    for (int k = 0; k < 3; k++) begin
      bus.btn_1 = 1; repeat (2) @(negedge clk);
      bus.btn_1 = 0; repeat (2) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check("glitch_q", {4'd0, bus.q}, 8'h0a);
    check("glitch_cnt", bus.cp_cnt, 8'd1);
    press(2'd0, 4'b0011, 4'b0000);
    press(2'd1, 4'b0110, 4'b0000);
    check("t1_q", {4'd0, bus.q}, 8'h05);
    press(2'd1, 4'b0110, 4'b0000);
    check("t2_q", {4'd0, bus.q}, 8'h03);
    check("t_cnt", bus.cp_cnt, 8'd4);
    press(2'd0, 4'b0000, 4'b0000);
    press(2'd2, 4'b1100, 4'b1010);
    check("jk_q", {4'd0, bus.q}, 8'h0c);
    press(2'd0, 4'b0101, 4'b0000);
    press(2'd3, 4'b1001, 4'b1010);
    check("sr_q", {4'd0, bus.q}, 8'h05);
    check("sr_err", {7'd0, bus.err}, 8'h01);
    bus.mode_sel = 2'd0; bus.a_in = 4'b1111;
    @(negedge clk);
    check("err_clr", {7'd0, bus.err}, 8'h00);
    check("mode_no_cp_q", {4'd0, bus.q}, 8'h05);
    bus.rd_n = 0; bus.sd_n = 0;
    repeat (3) @(negedge clk);
    press(2'd0, 4'b1111, 4'b0000);
    check("rdsd_q", {4'd0, bus.q}, 8'h00);
    check("rdsd_cnt", bus.cp_cnt, 8'd9);
    bus.sd_n = 1; repeat (4) @(negedge clk);
    check("rd_only_q", {4'd0, bus.q}, 8'h00);
    bus.rd_n = 1; bus.sd_n = 0; repeat (4) @(negedge clk);
    check("sd_only_q", {4'd0, bus.q}, 8'h0f);
    bus.sd_n = 1; repeat (3) @(negedge clk);
    for (int i = 0; i < 247; i++) press(2'd0, 4'(i), 4'b0000);
    check("wrap_cnt", bus.cp_cnt, 8'd0);
    check("wrap_q", {4'd0, bus.q}, 8'h06);
    @(negedge clk);
    bus.a_in = 4'b1001; bus.btn_1 = 1;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    check("async_q", {4'd0, bus.q}, 8'h00);
    check("async_q_n", {4'd0, bus.q_n}, 8'h0f);
    @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);
    check("rst_window_cnt", bus.cp_cnt, 8'd0);
    repeat (5) @(negedge clk);
    check("rst_press_cnt", bus.cp_cnt, 8'd1);
    check("rst_press_q", {4'd0, bus.q}, 8'h09);
    bus.btn_1 = 0;
    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
